iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, located in the EX stage.
- Drives the stall request that freezes the EX-side pipeline registers while a division runs.
- Returns quotient (LO) and remainder (HI) in the cycle that releases the stall.
- Honours flush by abandoning an in-flight division.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- start_i  in  1  EX holds a DIV/DIVU; sampled only in IDLE.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- a_i  in  WIDTH  dividend (rs).
- b_i  in  WIDTH  divisor (rt).
- cancel_i  in  1  flush of EX; aborts the operation.
- stall_o  out  1  stall request to pipeline registers.
- done_o  out  1  result valid, single-cycle pulse.
- quot_o  out  WIDTH  quotient, to LO.
- rem_o  out  WIDTH  remainder, to HI.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, partial remainder/quotient regs=0.
  - done_o=0, quot_o=0, rem_o=0.
  - stall_o=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall_o = start_i & ~cancel_i (combinational).
  - On an accepted start, latch |a|, |b|, sign_q=a[MSB]^b[MSB] and sign_r=a[MSB]. Signs are used only when signed_i=1.
  - If b_i==0 -> DONE; otherwise -> BUSY with counter=WIDTH-1.
- BUSY:
  - stall_o=1.
  - One restoring step per cycle: shift {rem,quot} left 1; trial = rem - |b|; if no borrow, rem=trial and quot[0]=1.
  - At counter==0 -> DONE; otherwise counter decrements.
- DONE:
  - stall_o=0, done_o=1. quot_o/rem_o are valid this cycle.
  - Sign fix-up: quot negated if sign_q, rem negated if sign_r (signed only).
  - Next state is always IDLE. start_i is ignored here because the same instruction is still in EX.
- Latency: accept cycle 0, BUSY cycles 1..WIDTH, DONE cycle WIDTH+1.
  - stall_o is high WIDTH+1 cycles (33 for WIDTH=32).
  - A back-to-back divide is accepted at cycle WIDTH+2 at the earliest.
- quot_o/rem_o:
  - Registered values, held stable after DONE until the next accepted start.
  - In BUSY they show intermediate values; consumers qualify them with done_o.
- Divide by zero: result is quot=all-ones, rem=dividend (raw a_i, no sign fix-up). Reached via IDLE->DONE, so stall_o is high for 1 cycle.
- Overflow: signed -2^(WIDTH-1) / -1 gives quot=0x80000000, rem=0 (natural wrap). No trap.
- cancel_i:
  - In any state, forces IDLE on the next edge with done_o=0 and output registers unchanged.
  - In IDLE, cancel wins over start_i.
  - In DONE, done_o is suppressed in that cycle (combinational gate).
- Reset mid-BUSY: immediate IDLE, and stall_o drops asynchronously.
- Arithmetic: the trial subtraction is WIDTH+1 bits wide, and the borrow is taken from the MSB.

Decomposition:
- Shared package (alongside the existing width defines):
  - div_state_t enum {IDLE, BUSY, DONE}.
  - DIV_ZERO_QUOT constant (all-ones).
- One sub-module is natural: div_abs_neg. It is combinational conditional two's-complement negate, instantiated for operand magnitudes and for result fix-up.
- The FSM and datapath stay in iter_divider.

Test Plan:
- DIVU 100/7, start held high -> stall_o high 33 cycles, then done_o=1 with quot=14, rem=2. start is ignored in DONE and no second run occurs.
- DIV -7/2 (0xFFFFFFF9/2) -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1). DIV 7/-2 -> quot=-3, rem=1.
- DIV 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0. DIVU 0xFFFFFFFF/1 -> quot=0xFFFFFFFF, rem=0.
- DIVU 5/0 -> stall_o high exactly 1 cycle, then done_o with quot=0xFFFFFFFF, rem=5.
- Start 100/7, cancel_i at BUSY cycle 10 -> IDLE next cycle, stall_o=0, no done_o, previous quot_o/rem_o unchanged. An immediate new 9/3 then yields quot=3, rem=0.
- Pull rst low at BUSY cycle 5, asynchronously and off-edge -> stall_o, done_o and outputs go to 0 without waiting for a clock edge. Release and run 9/3 -> correct result.

Source files
------------

// File: rtl/iter_divider_pkg.sv
// iter_divider_pkg: shared definitions for the EX-stage iterative divider.
//   - DIV_W          : native datapath width of the core
//   - div_state_t    : divider FSM states (IDLE/BUSY/DONE)
//   - DIV_ZERO_QUOT  : quotient returned on divide-by-zero (all-ones,
//                      sliced to the instance width)
package iter_divider_pkg;

   localparam int DIV_W     = 32;
   localparam int DIV_MAX_W = 64;

   // Encodings kept as plain constants so older code comparing raw state
   // bits keeps working; the enum is built on top of them.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY,
      DONE = ST_DONE
   } div_state_t;

   localparam logic [DIV_MAX_W-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/iter_divider_abs_neg.sv
// div_abs_neg: combinational conditional two's-complement negate.
//   val : input value
//   neg : 1 = output -val, 0 = pass val through
//   res : result
// Used both to take operand magnitudes and to apply the result sign fix-up.
module div_abs_neg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val,
   input  logic             neg,
   output logic [WIDTH-1:0] res
);

   assign res = neg ? (~val + 1'b1) : val;

endmodule

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
//   clk, rst     : clock, asynchronous active-low reset
//   start_i      : EX holds a divide (sampled only in IDLE)
//   signed_i     : 1 = DIV (two's complement), 0 = DIVU
//   a_i, b_i     : dividend (rs), divisor (rt)
//   cancel_i     : EX flush, abandons any operation in flight
//   stall_o      : freezes EX-side pipeline registers while dividing
//   done_o       : one-cycle result-valid pulse
//   quot_o/rem_o : quotient (LO) / remainder (HI), registered
// Timing: accept cycle 0, WIDTH BUSY cycles, DONE at cycle WIDTH+1.
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int WIDTH = DIV_W,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cancel_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_q;    // partial remainder
   logic [WIDTH-1:0] quot_q;   // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] dvsr_q;   // divisor magnitude
   logic             sign_q;   // negate quotient at the end
   logic             sign_r;   // negate remainder at the end

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_sh, trial;
   logic             borrow;
   logic [WIDTH-1:0] rem_nxt, quot_nxt, quot_fix, rem_fix;

   div_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
      .val (a_i),
      .neg (signed_i & a_i[WIDTH-1]),
      .res (a_mag)
   );

   div_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
      .val (b_i),
      .neg (signed_i & b_i[WIDTH-1]),
      .res (b_mag)
   );

   // One restoring step. The shifted remainder can reach 2*|b|-1, so the
   // trial subtraction needs an extra bit; its MSB is the borrow.
   always_comb begin
      rem_sh   = {rem_q, quot_q[WIDTH-1]};
      trial    = rem_sh - {1'b0, dvsr_q};
      borrow   = trial[WIDTH];
      rem_nxt  = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      quot_nxt = {quot_q[WIDTH-2:0], ~borrow};
   end

   // Sign fix-up applied on the final step so DONE presents signed results.
   div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (
      .val (quot_nxt),
      .neg (sign_q),
      .res (quot_fix)
   );

   div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (
      .val (rem_nxt),
      .neg (sign_r),
      .res (rem_fix)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         rem_q  <= '0;
         quot_q <= '0;
         dvsr_q <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         quot_o <= '0;
         rem_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i && !cancel_i) begin
                  sign_q <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  sign_r <= signed_i & a_i[WIDTH-1];
                  dvsr_q <= b_mag;
                  rem_q  <= '0;
                  quot_q <= a_mag;
                  if (b_i == '0) begin
                     // Divide by zero skips BUSY; remainder is the raw dividend.
                     state  <= DONE;
                     quot_o <= DIV_ZERO_QUOT[WIDTH-1:0];
                     rem_o  <= a_i;
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_W'(WIDTH-1);
                  end
               end
            end
            BUSY: begin
               if (cancel_i) begin
                  state <= IDLE;
               end else begin
                  rem_q  <= rem_nxt;
                  quot_q <= quot_nxt;
                  if (cnt == '0) begin
                     state  <= DONE;
                     quot_o <= quot_fix;
                     rem_o  <= rem_fix;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            // The instruction that started us is still in EX, so a held
            // start_i must not launch a second run from here.
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Gated with rst so the stall drops the moment reset is asserted, even if
   // EX still presents a divide.
   always_comb begin
      stall_o = 1'b0;
      if (rst) begin
         case (state)
            IDLE:    stall_o = start_i & ~cancel_i;
            BUSY:    stall_o = 1'b1;
            default: stall_o = 1'b0;
         endcase
      end
   end

   assign done_o = rst & (state == DONE) & ~cancel_i;

endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        signed_i = 1'b0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        cancel_i = 1'b0;
   logic        stall_o, done_o;
   logic [31:0] quot_o, rem_o;

   int n_chk  = 0;
   int n_pass = 0;
   bit cmp_en = 1'b0;

   iter_divider #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .signed_i (signed_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .cancel_i (cancel_i),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .quot_o   (quot_o),
      .rem_o    (rem_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Reference division from the ISA rules: truncating division, remainder
   // takes the dividend's sign, /0 gives all-ones and the raw dividend.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      longint sa, sb, q, r;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {q[31:0], r[31:0]};
   endfunction

   // Transaction-level model: an accepted divide finishes 32 cycles of work
   // (none for /0), then one result cycle; cancel abandons it.
   bit          m_act;
   int          m_left;
   logic [31:0] m_q, m_r;
   logic [63:0] m_pend;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_act  <= 1'b0;
         m_left <= 0;
         m_q    <= '0;
         m_r    <= '0;
         m_pend <= '0;
      end else if (!m_act) begin
         if (start_i && !cancel_i) begin
            m_act  <= 1'b1;
            m_pend <= ref_div(a_i, b_i, signed_i);
            if (b_i == 32'd0) begin
               m_left     <= 0;
               {m_q, m_r} <= ref_div(a_i, b_i, signed_i);
            end else begin
               m_left <= 32;
            end
         end
      end else if (cancel_i || m_left == 0) begin
         m_act <= 1'b0;
      end else begin
         m_left <= m_left - 1;
         if (m_left == 1) {m_q, m_r} <= m_pend;
      end
   end

   always @(negedge clk) begin
      if (rst && cmp_en) begin
         bit in_done, e_stall, e_done;
         in_done = m_act && (m_left == 0);
         e_stall = m_act ? !in_done : (start_i && !cancel_i);
         e_done  = in_done && !cancel_i;
         chk("cmp.stall", {63'd0, stall_o}, {63'd0, e_stall});
         chk("cmp.done",  {63'd0, done_o},  {63'd0, e_done});
         if (!m_act || in_done) begin
            chk("cmp.quot", {32'd0, quot_o}, {32'd0, m_q});
            chk("cmp.rem",  {32'd0, rem_o},  {32'd0, m_r});
         end
      end
   end

   // Holds start until done_o, counts stall cycles, then drops start and
   // confirms no second run is launched.
   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                         input int est);
      int n;
      bit got;
      @(posedge clk); #1;
      a_i = a; b_i = b; signed_i = sgn; start_i = 1'b1; cancel_i = 1'b0;
      n = 0;
      got = 1'b0;
      for (int k = 0; k < 80 && !got; k++) begin
         @(negedge clk);
         if (done_o) begin
            got = 1'b1;
            chk({nm, ".quot"},  {32'd0, quot_o}, {32'd0, eq});
            chk({nm, ".rem"},   {32'd0, rem_o},  {32'd0, er});
            chk({nm, ".stall"}, 64'(n), 64'(est));
         end else if (stall_o) begin
            n++;
         end
      end
      chk({nm, ".done_seen"}, {63'd0, got}, 64'd1);
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      chk({nm, ".no_rerun"}, {62'd0, stall_o, done_o}, 64'd0);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      chk("rst.stall", {63'd0, stall_o}, 64'd0);
      chk("rst.done",  {63'd0, done_o},  64'd0);
      chk("rst.quot",  {32'd0, quot_o},  64'd0);
      chk("rst.rem",   {32'd0, rem_o},   64'd0);
      #2 rst = 1'b1;
      cmp_en = 1'b1;

      run_op("divu_100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33);
      run_op("div_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
      run_op("div_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          33);
      run_op("div_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          33);
      run_op("divu_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          33);
      run_op("div_m9_m4",   32'hFFFF_FFF7,  32'hFFFF_FFFC,  1'b1, 32'd2,          32'hFFFF_FFFF,  33);
      run_op("divu_big",    32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 32'd1,          32'h7FFF_FFFF,  33);
      run_op("divu_5_0",    32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1);
      run_op("div_m5_0",    32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1);

      // Cancel at BUSY cycle 10: previous result (-5/0) must survive.
      @(posedge clk); #1;
      a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      cancel_i = 1'b1;
      start_i  = 1'b0;
      @(negedge clk);
      chk("cancel.busy_stall", {63'd0, stall_o}, 64'd1);
      chk("cancel.busy_done",  {63'd0, done_o},  64'd0);
      @(posedge clk); #1;
      cancel_i = 1'b0;
      @(negedge clk);
      chk("cancel.stall", {63'd0, stall_o}, 64'd0);
      chk("cancel.done",  {63'd0, done_o},  64'd0);
      chk("cancel.quot",  {32'd0, quot_o},  {32'd0, 32'hFFFF_FFFF});
      chk("cancel.rem",   {32'd0, rem_o},   {32'd0, 32'hFFFF_FFFB});
      run_op("after_cancel_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);

      // Asynchronous reset in BUSY cycle 5, off the clock edge.
      @(posedge clk); #1;
      a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst.stall", {63'd0, stall_o}, 64'd0);
      chk("arst.done",  {63'd0, done_o},  64'd0);
      chk("arst.quot",  {32'd0, quot_o},  64'd0);
      chk("arst.rem",   {32'd0, rem_o},   64'd0);
      start_i = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      run_op("after_rst_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
